// File: rtl/move_scheduler.sv
// Two-requester descriptor scheduler: round-robin arbiter feeding a small FIFO,
// and a sequencer that starts one data-mover job at a time with a per-phase timeout.
module move_scheduler #(
    parameter int ADDR_WIDTH = 32,
    parameter int DEPTH      = 4,
    parameter int TIMEOUT    = 1024
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [1:0]              req_valid,
    output logic [1:0]              req_ready,
    input  logic [2*ADDR_WIDTH-1:0] req_src,
    input  logic [2*ADDR_WIDTH-1:0] req_dest,
    input  logic [2*ADDR_WIDTH-1:0] req_len,
    input  logic [15:0]             req_mask,
    output logic [ADDR_WIDTH-1:0]   mv_src,
    output logic [ADDR_WIDTH-1:0]   mv_dest,
    output logic [ADDR_WIDTH-1:0]   mv_len,
    output logic [7:0]              mv_mask,
    output logic                    mv_en,
    input  logic                    mv_done,
    output logic                    cpl_valid,
    output logic                    cpl_id,
    output logic                    cpl_err,
    output logic                    busy,
    output logic [$clog2(DEPTH):0]  fifo_count
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam int TW = $clog2(TIMEOUT);

    typedef struct packed {
        logic                  id;
        logic [ADDR_WIDTH-1:0] src;
        logic [ADDR_WIDTH-1:0] dest;
        logic [ADDR_WIDTH-1:0] len;
        logic [7:0]            mask;
    } desc_t;

    typedef enum logic [2:0] {
        S_IDLE,
        S_ISSUE,
        S_ACK,
        S_RUN,
        S_CPL
    } state_t;

    desc_t         w_req_desc [2];
    desc_t         r_mem [DEPTH];
    desc_t         w_head;
    desc_t         r_mv;

    logic [PW-1:0] r_wr_ptr;
    logic [PW-1:0] r_rd_ptr;
    logic [CW-1:0] r_count;
    logic          r_prio;

    logic          w_gnt_valid;
    logic          w_gnt_id;
    logic          w_full;
    logic          w_empty;
    logic          w_deq;
    logic          w_can_enq;
    logic          w_enq;

    state_t        r_state;
    state_t        w_state_next;
    logic [TW-1:0] r_tmr;
    logic          w_tmr_clr;
    logic          w_tmr_inc;
    logic          w_tmr_last;
    logic          w_err_set;
    logic          r_err;

    genvar gi;

    // Per-requester descriptor unpacking and handshake
    generate
        for (gi = 0; gi < 2; gi++) begin : g_req
            assign w_req_desc[gi] = {1'(gi),
                                     req_src[gi*ADDR_WIDTH +: ADDR_WIDTH],
                                     req_dest[gi*ADDR_WIDTH +: ADDR_WIDTH],
                                     req_len[gi*ADDR_WIDTH +: ADDR_WIDTH],
                                     req_mask[gi*8 +: 8]};
            assign req_ready[gi]  = w_can_enq & w_gnt_valid & (w_gnt_id == 1'(gi));
        end
    endgenerate

    always_comb begin
        w_gnt_valid = 1'b0;
        w_gnt_id    = r_prio;
        if (req_valid[r_prio]) begin
            w_gnt_valid = 1'b1;
            w_gnt_id    = r_prio;
        end else if (req_valid[~r_prio]) begin
            w_gnt_valid = 1'b1;
            w_gnt_id    = ~r_prio;
        end
    end

    assign w_full    = (r_count == CW'(DEPTH));
    assign w_empty   = (r_count == '0);
    assign w_deq     = (r_state == S_IDLE) && !w_empty;
    // A full FIFO still accepts when the head leaves in the same cycle
    assign w_can_enq = !rst && (!w_full || w_deq);
    assign w_enq     = |(req_valid & req_ready);
    assign w_head    = r_mem[r_rd_ptr];

    always_ff @(posedge clk) begin
        if (w_enq) begin
            r_mem[r_wr_ptr] <= w_req_desc[w_gnt_id];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
            r_prio   <= 1'b0;
        end else begin
            if (w_enq) begin
                r_wr_ptr <= r_wr_ptr + PW'(1);
                r_prio   <= ~w_gnt_id;
            end
            if (w_deq) begin
                r_rd_ptr <= r_rd_ptr + PW'(1);
            end
            r_count <= r_count + CW'(w_enq) - CW'(w_deq);
        end
    end

    assign w_tmr_last = (r_tmr == TW'(TIMEOUT - 1));

    always_comb begin
        w_state_next = r_state;
        w_tmr_clr    = 1'b0;
        w_tmr_inc    = 1'b0;
        w_err_set    = 1'b0;
        mv_en        = 1'b0;
        cpl_valid    = 1'b0;
        unique case (r_state)
            S_IDLE: begin
                if (!w_empty) begin
                    w_state_next = (w_head.len == '0) ? S_CPL : S_ISSUE;
                end
            end
            S_ISSUE: begin
                mv_en        = !rst;
                w_tmr_clr    = 1'b1;
                w_state_next = S_ACK;
            end
            S_ACK: begin
                if (!mv_done) begin
                    w_tmr_clr    = 1'b1;
                    w_state_next = S_RUN;
                end else if (w_tmr_last) begin
                    w_err_set    = 1'b1;
                    w_state_next = S_CPL;
                end else begin
                    w_tmr_inc = 1'b1;
                end
            end
            S_RUN: begin
                if (mv_done) begin
                    w_state_next = S_CPL;
                end else if (w_tmr_last) begin
                    w_err_set    = 1'b1;
                    w_state_next = S_CPL;
                end else begin
                    w_tmr_inc = 1'b1;
                end
            end
            S_CPL: begin
                cpl_valid    = !rst;
                w_state_next = S_IDLE;
            end
            default: begin
                w_state_next = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_tmr   <= '0;
            r_err   <= 1'b0;
            r_mv    <= '0;
        end else begin
            r_state <= w_state_next;
            if (w_tmr_clr) begin
                r_tmr <= '0;
            end else if (w_tmr_inc) begin
                r_tmr <= r_tmr + TW'(1);
            end
            if (w_deq) begin
                r_mv  <= w_head;
                r_err <= 1'b0;
            end else if (w_err_set) begin
                r_err <= 1'b1;
            end
        end
    end

    // Outputs read as zero for the whole time reset is held
    assign mv_src     = rst ? '0 : r_mv.src;
    assign mv_dest    = rst ? '0 : r_mv.dest;
    assign mv_len     = rst ? '0 : r_mv.len;
    assign mv_mask    = rst ? '0 : r_mv.mask;
    assign cpl_id     = cpl_valid & r_mv.id;
    assign cpl_err    = cpl_valid & r_err;
    assign busy       = !rst && ((r_state != S_IDLE) || !w_empty);
    assign fifo_count = rst ? '0 : r_count;

endmodule

// File: tb/tb_move_scheduler.sv
// Bench for move_scheduler: queue-based reference model checked every cycle,
// a scripted mover, and directed scenarios with hand-derived event timing.
module tb_move_scheduler;

    localparam int AW      = 32;
    localparam int DEPTH   = 4;
    localparam int TIMEOUT = 16;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic [1:0]    req_valid = '0;
    logic [1:0]    req_ready;
    logic [2*AW-1:0] req_src = '0;
    logic [2*AW-1:0] req_dest = '0;
    logic [2*AW-1:0] req_len = '0;
    logic [15:0]   req_mask = '0;
    logic [AW-1:0] mv_src, mv_dest, mv_len;
    logic [7:0]    mv_mask;
    logic          mv_en;
    logic          mv_done = 1'b1;
    logic          cpl_valid, cpl_id, cpl_err, busy;
    logic [$clog2(DEPTH):0] fifo_count;

    always #5 clk = ~clk;

    move_scheduler #(.ADDR_WIDTH(AW), .DEPTH(DEPTH), .TIMEOUT(TIMEOUT)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_src(req_src), .req_dest(req_dest), .req_len(req_len), .req_mask(req_mask),
        .mv_src(mv_src), .mv_dest(mv_dest), .mv_len(mv_len), .mv_mask(mv_mask),
        .mv_en(mv_en), .mv_done(mv_done),
        .cpl_valid(cpl_valid), .cpl_id(cpl_id), .cpl_err(cpl_err),
        .busy(busy), .fifo_count(fifo_count)
    );

    typedef struct {
        logic [31:0] src;
        logic [31:0] dest;
        logic [31:0] len;
        logic [7:0]  mask;
        logic        id;
    } d_t;

    typedef struct {
        int          cyc;
        logic [31:0] src;
        logic        id;
        logic        err;
    } ev_t;

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;

    // reference model: queue of pending jobs plus the job in flight
    d_t   mq[$];
    bit   m_prio;
    int   m_phase;      // 0 idle, 1 start pulse, 2 await done low, 3 await done high, 4 report
    int   m_spent;
    d_t   m_cur;
    bit   m_err;
    d_t   m_mv;

    int   acc_cyc[$];
    int   deq_cyc[$];
    int   gnt_log[$];
    ev_t  en_log[$];
    ev_t  cpl_log[$];

    // stimulus queues and mover script
    d_t   tx0[$];
    d_t   tx1[$];
    bit   acc0, acc1;
    bit   mv_pend;
    int   mv_k;
    int   nodrop_left = 0;
    bit   job_nodrop;
    bit   hold_low = 1'b0;

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s cyc=%0d got=0x%0h exp=0x%0h", name, cyc, got, exp);
        end
    endtask

    function automatic d_t zero_d();
        d_t z;
        z.src = '0; z.dest = '0; z.len = '0; z.mask = '0; z.id = 1'b0;
        return z;
    endfunction

    task automatic model_cycle();
        logic [1:0] e_ready = '0;
        logic e_en = 1'b0, e_cv = 1'b0, e_cid = 1'b0, e_cerr = 1'b0, e_busy = 1'b0;
        int   e_cnt = 0;
        d_t   e_mv = zero_d();
        int   g = -1;
        bit   deq = 1'b0;
        d_t   x;
        ev_t  ev;
        if (!rst) begin
            deq = (m_phase == 0) && (mq.size() > 0);
            if (req_valid[m_prio]) g = int'(m_prio);
            else if (req_valid[!m_prio]) g = int'(!m_prio);
            if (g >= 0 && (mq.size() < DEPTH || deq)) e_ready[g] = 1'b1;
            e_en   = (m_phase == 1);
            e_cv   = (m_phase == 4);
            e_cid  = e_cv & m_cur.id;
            e_cerr = e_cv & m_err;
            e_busy = (m_phase != 0) || (mq.size() > 0);
            e_cnt  = mq.size();
            e_mv   = m_mv;
        end
        chk("req_ready", req_ready, e_ready);
        chk("mv_en", mv_en, e_en);
        chk("cpl_valid", cpl_valid, e_cv);
        chk("cpl_id", cpl_id, e_cid);
        chk("cpl_err", cpl_err, e_cerr);
        chk("busy", busy, e_busy);
        chk("fifo_count", fifo_count, e_cnt);
        chk("mv_src", mv_src, e_mv.src);
        chk("mv_dest", mv_dest, e_mv.dest);
        chk("mv_len", mv_len, e_mv.len);
        chk("mv_mask", mv_mask, e_mv.mask);

        if (rst) begin
            mq.delete();
            m_prio = 1'b0; m_phase = 0; m_spent = 0; m_err = 1'b0;
            m_mv = zero_d(); m_cur = zero_d();
        end else begin
            case (m_phase)
                0: if (deq) begin
                    m_cur = mq.pop_front();
                    m_mv  = m_cur;
                    m_err = 1'b0;
                    deq_cyc.push_back(cyc);
                    m_phase = (m_cur.len == 0) ? 4 : 1;
                end
                1: begin
                    ev.cyc = cyc; ev.src = m_mv.src; ev.id = m_mv.id; ev.err = 1'b0;
                    en_log.push_back(ev);
                    m_phase = 2; m_spent = 0;
                end
                2, 3: begin
                    m_spent++;
                    if ((m_phase == 2 && !mv_done) || (m_phase == 3 && mv_done)) begin
                        m_phase = m_phase + 1; m_spent = 0;
                        if (m_phase == 3) m_spent = 0;
                    end else if (m_spent == TIMEOUT) begin
                        m_phase = 4; m_err = 1'b1;
                    end
                end
                default: begin
                    ev.cyc = cyc; ev.src = m_cur.src; ev.id = m_cur.id; ev.err = m_err;
                    cpl_log.push_back(ev);
                    m_phase = 0;
                end
            endcase
            if (g >= 0 && e_ready[g]) begin
                x.src  = req_src[g*AW +: AW];
                x.dest = req_dest[g*AW +: AW];
                x.len  = req_len[g*AW +: AW];
                x.mask = req_mask[g*8 +: 8];
                x.id   = g[0];
                mq.push_back(x);
                acc_cyc.push_back(cyc);
                gnt_log.push_back(g);
                m_prio = (g == 0);
            end
        end
    endtask

    task automatic present();
        req_valid = '0; req_src = '0; req_dest = '0; req_len = '0; req_mask = '0;
        if (tx0.size() > 0) begin
            req_valid[0] = 1'b1;
            req_src[31:0] = tx0[0].src; req_dest[31:0] = tx0[0].dest;
            req_len[31:0] = tx0[0].len; req_mask[7:0] = tx0[0].mask;
        end
        if (tx1.size() > 0) begin
            req_valid[1] = 1'b1;
            req_src[63:32] = tx1[0].src; req_dest[63:32] = tx1[0].dest;
            req_len[63:32] = tx1[0].len; req_mask[15:8] = tx1[0].mask;
        end
    endtask

    task automatic push(input int r, input logic [31:0] s, input logic [31:0] d,
                        input logic [31:0] l, input logic [7:0] m);
        d_t x;
        x.src = s; x.dest = d; x.len = l; x.mask = m; x.id = r[0];
        if (r == 0) tx0.push_back(x);
        else tx1.push_back(x);
        present();
    endtask

    task automatic tick();
        @(negedge clk);
        model_cycle();
        acc0 = req_valid[0] & req_ready[0];
        acc1 = req_valid[1] & req_ready[1];
        if (!rst && mv_en) begin
            mv_pend = 1'b1; mv_k = 0;
            job_nodrop = (nodrop_left > 0);
            if (job_nodrop) nodrop_left--;
        end
        @(posedge clk);
        #1;
        cyc++;
        if (acc0) void'(tx0.pop_front());
        if (acc1) void'(tx1.pop_front());
        present();
        if (rst) begin
            mv_pend = 1'b0; mv_done = 1'b1;
        end else if (mv_pend) begin
            mv_k++;
            if (job_nodrop) begin
                if (mv_k >= 13) mv_pend = 1'b0;
            end else begin
                if (mv_k == 3) mv_done = 1'b0;
                if (mv_k >= 13 && !hold_low) begin
                    mv_done = 1'b1; mv_pend = 1'b0;
                end
            end
        end
    endtask

    task automatic wait_idle(input string name, input int budget);
        int n = 0;
        while (!(tx0.size() == 0 && tx1.size() == 0 && m_phase == 0 && mq.size() == 0) && n < budget) begin
            tick();
            n++;
        end
        if (n >= budget) chk({name, "_idle_timeout"}, 1, 0);
        repeat (2) tick();
    endtask

    task automatic clear_logs();
        acc_cyc.delete(); deq_cyc.delete(); gnt_log.delete(); en_log.delete(); cpl_log.delete();
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick(); tick();
        rst = 1'b0;
        tick();
        clear_logs();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        bit saw3;
        int n;
        logic [31:0] e_src;

        // reset state
        tick(); tick();
        chk("rst_fifo_count_held", fifo_count, 0);
        chk("rst_busy_held", busy, 0);
        rst = 1'b0;
        tick();
        chk("rst_fifo_count", fifo_count, 0);
        chk("rst_busy", busy, 0);
        chk("rst_ready", req_ready, 0);
        clear_logs();

        // single move from requester 1
        push(1, 32'h1000, 32'h2000, 32'h40, 8'hFF);
        wait_idle("t1", 100);
        chk("t1_en_count", en_log.size(), 1);
        chk("t1_cpl_count", cpl_log.size(), 1);
        if (en_log.size() == 1 && cpl_log.size() == 1 && acc_cyc.size() == 1) begin
            chk("t1_en_src", en_log[0].src, 32'h1000);
            chk("t1_en_latency", en_log[0].cyc - acc_cyc[0], 2);
            chk("t1_cpl_latency", cpl_log[0].cyc - en_log[0].cyc, 14);
            chk("t1_cpl_id", cpl_log[0].id, 1);
            chk("t1_cpl_err", cpl_log[0].err, 0);
        end

        // arbitration, both requesters busy
        do_reset();
        for (int i = 0; i < 4; i++) begin
            push(0, 32'h100 + i, 32'h1100 + i, 32'h10, 8'h0F);
            push(1, 32'h200 + i, 32'h1200 + i, 32'h20, 8'hF0);
        end
        wait_idle("t2", 400);
        chk("t2_grants", gnt_log.size(), 8);
        chk("t2_cpls", cpl_log.size(), 8);
        for (int i = 0; i < 8 && i < gnt_log.size() && i < cpl_log.size(); i++) begin
            e_src = ((i % 2) == 0) ? 32'h100 + i / 2 : 32'h200 + i / 2;
            chk("t2_grant_order", gnt_log[i], i % 2);
            chk("t2_cpl_order", cpl_log[i].src, e_src);
            chk("t2_cpl_err", cpl_log[i].err, 0);
        end

        // full FIFO with the mover stalled
        clear_logs();
        hold_low = 1'b1;
        for (int i = 0; i < 6; i++) push(1, 32'h300 + i, 32'h1300 + i, 32'h8, 8'h55);
        saw3 = 1'b0;
        n = 0;
        while (fifo_count != 4 && n < 40) begin
            tick();
            if (fifo_count == 3) saw3 = 1'b1;
            n++;
        end
        chk("t3_saw_depth_minus1", saw3, 1);
        chk("t3_count_full", fifo_count, 4);
        tick(); tick();
        chk("t3_ready_low_full", req_ready, 0);
        chk("t3_count_hold", fifo_count, 4);
        hold_low = 1'b0;
        wait_idle("t3", 300);
        chk("t3_cpls", cpl_log.size(), 6);
        for (int i = 0; i < 6 && i < cpl_log.size(); i++) begin
            chk("t3_cpl_order", cpl_log[i].src, 32'h300 + i);
            chk("t3_cpl_err", cpl_log[i].err, 0);
        end

        // timeout followed by a normal job
        clear_logs();
        nodrop_left = 1;
        push(0, 32'h400, 32'h1400, 32'h10, 8'h0F);
        push(0, 32'h401, 32'h1401, 32'h10, 8'h0F);
        wait_idle("t4", 200);
        chk("t4_en_count", en_log.size(), 2);
        chk("t4_cpl_count", cpl_log.size(), 2);
        if (en_log.size() == 2 && cpl_log.size() == 2) begin
            chk("t4_err_first", cpl_log[0].err, 1);
            chk("t4_timeout_after_ack", cpl_log[0].cyc - (en_log[0].cyc + 1), 16);
            chk("t4_next_issue_gap", en_log[1].cyc - cpl_log[0].cyc, 2);
            chk("t4_second_src", cpl_log[1].src, 32'h401);
            chk("t4_second_err", cpl_log[1].err, 0);
            chk("t4_second_latency", cpl_log[1].cyc - en_log[1].cyc, 14);
        end

        // zero-length descriptor
        clear_logs();
        push(1, 32'h500, 32'h1500, 32'h0, 8'hAA);
        wait_idle("t5", 50);
        chk("t5_en_count", en_log.size(), 0);
        chk("t5_cpl_count", cpl_log.size(), 1);
        if (cpl_log.size() == 1 && deq_cyc.size() == 1) begin
            chk("t5_cpl_after_deq", cpl_log[0].cyc - deq_cyc[0], 1);
            chk("t5_cpl_err", cpl_log[0].err, 0);
            chk("t5_cpl_id", cpl_log[0].id, 1);
        end

        // reset while the mover is running with two queued
        clear_logs();
        for (int i = 0; i < 3; i++) push(0, 32'h600 + i, 32'h1600 + i, 32'h20, 8'h33);
        n = 0;
        while (mv_done != 1'b0 && n < 40) begin
            tick();
            n++;
        end
        chk("t6_reached_run", n < 40, 1);
        tick();
        chk("t6_queued", fifo_count, 2);
        clear_logs();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        tick();
        chk("t6_post_count", fifo_count, 0);
        chk("t6_post_busy", busy, 0);
        chk("t6_post_mv_src", mv_src, 0);
        repeat (30) tick();
        chk("t6_no_en", en_log.size(), 0);
        chk("t6_no_cpl", cpl_log.size(), 0);
        push(1, 32'h700, 32'h1700, 32'h8, 8'h01);
        wait_idle("t6", 100);
        chk("t6_new_en", en_log.size(), 1);
        chk("t6_new_cpl", cpl_log.size(), 1);
        if (cpl_log.size() == 1) begin
            chk("t6_new_src", cpl_log[0].src, 32'h700);
            chk("t6_new_err", cpl_log[0].err, 0);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
